// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event path: event encodings, per-button
// FSM states and default tick counts for the 1 MHz clock.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        EVT_SHORT        = 2'd0,
        EVT_LONG         = 2'd1,
        EVT_REPEAT       = 2'd2,
        EVT_RELEASE_LONG = 2'd3
    } evt_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_e;

    localparam int LONG_PRESS_TICKS_1MHZ = 1000000;
    localparam int REPEAT_TICKS_1MHZ     = 200000;

    // Counter width sized for the larger of the two thresholds (never below 1).
    function automatic int cnt_width(input int long_ticks, input int repeat_ticks);
        int m;
        m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_press_fsm.sv
// Per-button press classifier: edge detect, IDLE/PRESSED/HELD FSM and hold
// counter; pulses emit for one cycle with the event type.
module btn_press_fsm
    import btn_evt_pkg::*;
#(
    parameter int LONG_PRESS_TICKS = LONG_PRESS_TICKS_1MHZ,
    parameter int REPEAT_TICKS     = REPEAT_TICKS_1MHZ
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       emit,
    output evt_type_e  emit_type,
    output btn_state_e state
);

    localparam int CNT_W = cnt_width(LONG_PRESS_TICKS, REPEAT_TICKS);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    logic             prev_q;
    logic             press;
    logic             release_edge;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign press        = btn & ~prev_q;
    assign release_edge = ~btn & prev_q;
    assign state        = state_q;

    // prev resets high so a button held through reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            prev_q  <= btn;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_type = EVT_SHORT;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (release_edge) begin
                    emit      = 1'b1;
                    emit_type = EVT_SHORT;
                    state_d   = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    emit      = 1'b1;
                    emit_type = EVT_LONG;
                    state_d   = HELD;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                // Release outranks a REPEAT due in the same cycle.
                if (release_edge) begin
                    emit      = 1'b1;
                    emit_type = EVT_RELEASE_LONG;
                    state_d   = IDLE;
                end else if (cnt_q == REP_LAST) begin
                    emit      = 1'b1;
                    emit_type = EVT_REPEAT;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into SHORT/LONG/REPEAT/RELEASE_AFTER_LONG
// events, one pending slot per button, round-robin onto one event channel.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int N_BTN            = 4,
    parameter int LONG_PRESS_TICKS = LONG_PRESS_TICKS_1MHZ,
    parameter int REPEAT_TICKS     = REPEAT_TICKS_1MHZ,
    localparam int IDX_W           = $clog2(N_BTN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_BTN-1:0]   btn_clean,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDX_W-1:0]   evt_btn,
    output logic [1:0]         evt_type,
    output logic               overflow,
    input  logic               clr_overflow,
    output logic [2*N_BTN-1:0] fsm_state
);

    // Handshake: an event transfers on a rising edge with evt_valid && evt_ready;
    // while evt_valid && !evt_ready, evt_btn/evt_type hold their values.

    logic [N_BTN-1:0] emit;
    evt_type_e        emit_type [N_BTN];
    btn_state_e       btn_state [N_BTN];

    logic [N_BTN-1:0] pend_v_q, pend_v_d;
    evt_type_e        pend_t_q [N_BTN];
    evt_type_e        pend_t_d [N_BTN];
    logic [IDX_W-1:0] rr_q;
    logic             grant_v;
    logic [IDX_W-1:0] grant_idx;
    logic             load;
    logic             take;
    logic             drop;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_press_fsm #(
            .LONG_PRESS_TICKS (LONG_PRESS_TICKS),
            .REPEAT_TICKS     (REPEAT_TICKS)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn       (btn_clean[i]),
            .emit      (emit[i]),
            .emit_type (emit_type[i]),
            .state     (btn_state[i])
        );
        assign fsm_state[2*i +: 2] = btn_state[i];
    end

    assign load = !evt_valid || evt_ready;
    assign take = load && grant_v;

    // First pending slot after the last winner, wrapping modulo N_BTN.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            if (!grant_v && pend_v_q[(int'(rr_q) + k) % N_BTN]) begin
                grant_v   = 1'b1;
                grant_idx = IDX_W'((int'(rr_q) + k) % N_BTN);
            end
        end
    end

    // A slot being granted this cycle is free for a new event; otherwise a
    // second event on a full slot is dropped and the older one is kept.
    always_comb begin
        pend_v_d = pend_v_q;
        pend_t_d = pend_t_q;
        drop     = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (take && grant_idx == IDX_W'(i)) begin
                pend_v_d[i] = 1'b0;
            end
            if (emit[i]) begin
                if (!pend_v_d[i]) begin
                    pend_v_d[i] = 1'b1;
                    pend_t_d[i] = emit_type[i];
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                pend_t_q[i] <= EVT_SHORT;
            end
            rr_q      <= IDX_W'(N_BTN - 1);
            evt_valid <= 1'b0;
            evt_btn   <= '0;
            evt_type  <= 2'd0;
            overflow  <= 1'b0;
        end else begin
            pend_v_q <= pend_v_d;
            pend_t_q <= pend_t_d;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            if (load) begin
                if (grant_v) begin
                    evt_valid <= 1'b1;
                    evt_btn   <= grant_idx;
                    evt_type  <= pend_t_q[grant_idx];
                    rr_q      <= grant_idx;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random button activity,
// checked against a duration-based event model and a scoreboard queue.
module tb_button_event_ctrl;

    localparam int N  = 4;
    localparam int LP = 10;
    localparam int RP = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  btn_clean = '0;
    logic          evt_ready = 1'b1;
    logic          clr_overflow = 1'b0;
    logic          evt_valid;
    logic [IW-1:0] evt_btn;
    logic [1:0]    evt_type;
    logic          overflow;
    logic [2*N-1:0] fsm_state;

    button_event_ctrl #(
        .N_BTN            (N),
        .LONG_PRESS_TICKS (LP),
        .REPEAT_TICKS     (RP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_clean    (btn_clean),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_btn      (evt_btn),
        .evt_type     (evt_type),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int n_hs   = 0;
    logic [IW+1:0] exp_q[$];
    logic [IW-1:0] hs_btn_q[$];
    logic [1:0]    hs_type_q[$];
    logic [IW+1:0] exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Events follow from how long each button has been held (press-edge cycle
    // to current cycle); delivery uses one slot per button and one output.
    int            cyc;
    int            since [N];
    logic [N-1:0]  m_prev;
    logic          m_sv [N];
    logic [1:0]    m_st [N];
    logic          m_valid;
    logic [IW-1:0] m_btn;
    logic [1:0]    m_type;
    int            m_last;
    logic          m_ovf;
    logic          m_drop;
    logic          m_found;
    int            m_d;
    int            m_ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc     = 0;
            m_prev  = '1;
            m_valid = 1'b0;
            m_btn   = '0;
            m_type  = 2'd0;
            m_last  = N - 1;
            m_ovf   = 1'b0;
            for (int i = 0; i < N; i++) begin
                since[i] = -1;
                m_sv[i]  = 1'b0;
                m_st[i]  = 2'd0;
            end
            exp_q.delete();
        end else begin
            cyc++;
            if (!m_valid || evt_ready) begin
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (!m_found && m_sv[j]) begin
                        m_found = 1'b1;
                        m_valid = 1'b1;
                        m_btn   = IW'(j);
                        m_type  = m_st[j];
                        m_sv[j] = 1'b0;
                        m_last  = j;
                        exp_q.push_back({IW'(j), m_st[j]});
                    end
                end
                if (!m_found) m_valid = 1'b0;
            end
            m_drop = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_ev = -1;
                if (since[i] < 0) begin
                    if (btn_clean[i] && !m_prev[i]) since[i] = cyc;
                end else begin
                    m_d = cyc - since[i];
                    if (!btn_clean[i]) begin
                        m_ev     = (m_d <= LP) ? 0 : 3;
                        since[i] = -1;
                    end else if (m_d == LP) begin
                        m_ev = 1;
                    end else if (m_d > LP && ((m_d - LP) % RP) == 0) begin
                        m_ev = 2;
                    end
                end
                if (m_ev >= 0) begin
                    if (!m_sv[i]) begin
                        m_sv[i] = 1'b1;
                        m_st[i] = 2'(m_ev);
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end
            m_prev = btn_clean;
            if (m_drop) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
        end
    end

    function automatic bit model_busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < N; i++) b = b | m_sv[i];
        return b;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        #1;
        check("evt_valid", evt_valid, m_valid);
        check("overflow", overflow, m_ovf);
        if (evt_valid && m_valid) begin
            check("evt_btn", evt_btn, m_btn);
            check("evt_type", evt_type, m_type);
        end
        if (evt_valid && evt_ready) begin
            n_hs++;
            hs_btn_q.push_back(evt_btn);
            hs_type_q.push_back(evt_type);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hs_unexpected: got btn=%0d type=%0d required none", evt_btn, evt_type);
            end else begin
                exp_e = exp_q.pop_front();
                check("hs_btn", evt_btn, exp_e[IW+1:2]);
                check("hs_type", evt_type, exp_e[1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        tick(2);
        while ((evt_valid || exp_q.size() != 0 || model_busy()) && t < 200) begin
            tick(1);
            t++;
        end
        check(name, (t < 200), 1);
    endtask

    int h0;
    int lat;

    initial begin
        rst_n        = 1'b0;
        btn_clean    = '0;
        evt_ready    = 1'b1;
        clr_overflow = 1'b0;
        tick(3);
        check("rst_valid", evt_valid, 0);
        check("rst_btn", evt_btn, 0);
        check("rst_type", evt_type, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        tick(2);

        // Simultaneous releases, twice: btn 0 then btn 3 both times.
        for (int r = 0; r < 2; r++) begin
            h0 = n_hs;
            btn_clean[0] = 1'b1;
            btn_clean[3] = 1'b1;
            tick(3);
            btn_clean[0] = 1'b0;
            btn_clean[3] = 1'b0;
            drain("sim_drain");
            check("sim_count", n_hs - h0, 2);
            check("sim_first", hs_btn_q[h0], 0);
            check("sim_second", hs_btn_q[h0+1], 3);
        end

        // Short press on btn 2 with output latency.
        h0 = n_hs;
        btn_clean[2] = 1'b1;
        tick(5);
        btn_clean[2] = 1'b0;
        lat = 0;
        while (!evt_valid && lat < 10) begin
            tick(1);
            lat++;
        end
        check("short_latency", lat, 2);
        check("short_btn", evt_btn, 2);
        check("short_type", evt_type, 0);
        drain("short_drain");
        check("short_count", n_hs - h0, 1);

        // Long hold on btn 1: LONG, REPEAT, REPEAT, RELEASE_AFTER_LONG.
        h0 = n_hs;
        btn_clean[1] = 1'b1;
        tick(22);
        btn_clean[1] = 1'b0;
        drain("long_drain");
        check("long_count", n_hs - h0, 4);
        check("long_t0", hs_type_q[h0], 1);
        check("long_t1", hs_type_q[h0+1], 2);
        check("long_t2", hs_type_q[h0+2], 2);
        check("long_t3", hs_type_q[h0+3], 3);

        // Backpressure: output stalls on LONG, one REPEAT queued, rest dropped.
        h0 = n_hs;
        evt_ready    = 1'b0;
        btn_clean[1] = 1'b1;
        tick(29);
        btn_clean[1] = 1'b0;
        tick(1);
        check("bp_overflow", overflow, 1);
        check("bp_hold_valid", evt_valid, 1);
        check("bp_hold_type", evt_type, 1);
        evt_ready = 1'b1;
        drain("bp_drain");
        check("bp_count", n_hs - h0, 2);
        check("bp_second", hs_type_q[h0+1], 2);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        tick(1);
        check("bp_cleared", overflow, 0);

        // Held through reset: no event until a fresh press.
        rst_n     = 1'b0;
        btn_clean = 4'b0001;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        h0 = n_hs;
        btn_clean = '0;
        drain("htr_drain");
        check("htr_none", n_hs - h0, 0);
        btn_clean[0] = 1'b1;
        tick(3);
        btn_clean[0] = 1'b0;
        drain("htr_drain2");
        check("htr_short", n_hs - h0, 1);
        check("htr_type", hs_type_q[h0], 0);

        // Reset mid-hold with events pending and overflow set.
        evt_ready    = 1'b0;
        btn_clean[2] = 1'b1;
        tick(2);
        btn_clean[2] = 1'b0;
        tick(3);
        for (int r = 0; r < 2; r++) begin
            btn_clean[1] = 1'b1;
            tick(2);
            btn_clean[1] = 1'b0;
            tick(2);
        end
        check("mid_pre_ovf", overflow, 1);
        btn_clean[0] = 1'b1;
        tick(6);
        rst_n = 1'b0;
        #2;
        check("mid_valid", evt_valid, 0);
        check("mid_ovf", overflow, 0);
        tick(1);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        h0 = n_hs;
        tick(3);
        btn_clean[0] = 1'b0;
        drain("mid_drain");
        check("mid_no_stale", n_hs - h0, 0);

        // Random activity with random backpressure and overflow clears.
        for (int c = 0; c < 900; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) btn_clean[i] = ~btn_clean[i];
            end
            evt_ready    = ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 31) == 0);
            tick(1);
        end
        btn_clean    = '0;
        evt_ready    = 1'b1;
        clr_overflow = 1'b0;
        drain("rand_drain");

        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
